// File: rtl/mac_pkg.sv
// Shared constants for the multiply-accumulate datapath: product width, state
// encoding and a constant-evaluable clog2 for deriving counter widths.
package mac_pkg;

    localparam int unsigned PROD_W = 8;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        longint unsigned pow;
        res = 0;
        pow = 1;
        while (pow < longint'(value)) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Product-in / result-out handshake bundle between the multiplier feed and the
// accumulate stage.
interface mac_accum_if
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, prod, in_last, out_ready,
        input  in_ready, out_valid, acc_out, out_count, out_ovf
    );

    modport slave (
        input  in_valid, prod, in_last, out_ready,
        output in_ready, out_valid, acc_out, out_count, out_ovf
    );
endinterface

// File: rtl/arrmul.sv
// 4x4 unsigned combinational array multiplier: sum of shifted partial products.
module arrmul (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] mul_o
);
    always_comb begin
        mul_o = '0;
        for (int i = 0; i < 4; i++) begin
            if (b_i[i]) mul_o = mul_o + (8'(a_i) << i);
        end
    end
endmodule

// File: rtl/mac_accum.sv
// Frame accumulator: sums up to N_TERMS products per frame, then holds the
// result on a valid/ready port until it is taken.
module mac_accum
    import mac_pkg::*;
#(
    parameter int unsigned N_TERMS = 16,
    parameter int unsigned ACC_W   = 12
) (
    input logic       clk,
    input logic       rst,
    mac_accum_if.slave bus
);
    localparam int unsigned CNT_W = clog2(N_TERMS + 1);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d;
    logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;

    logic [ACC_W:0]   sum;
    logic             accept;
    logic             close;

    // One spare bit on top of the accumulator captures the carry-out of this add.
    assign sum    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod};
    assign accept = bus.in_valid && (state_q == ST_ACCUM);
    assign close  = accept && (bus.in_last || (cnt_q == CNT_W'(N_TERMS - 1)));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (state_q == ST_ACCUM) begin
            if (accept) begin
                acc_d = sum[ACC_W-1:0];
                ovf_d = ovf_q | sum[ACC_W];
                cnt_d = cnt_q + 1'b1;
                if (close) begin
                    state_d     = ST_HOLD;
                    acc_out_d   = sum[ACC_W-1:0];
                    out_count_d = cnt_q + 1'b1;
                    out_ovf_d   = ovf_q | sum[ACC_W];
                end
            end
        end else if (bus.out_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.acc_out   = acc_out_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
